// File: rtl/uart_frame_sender.sv
// uart_frame_sender
//   Owns the byte interface of a uart_tx. A start request latches a
//   fixed-length payload. The block then sends it as one frame:
//   SOF_BYTE, then the payload bytes (least significant byte first), then
//   the XOR of all payload bytes.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     frame request, honoured only while idle
//   payload   frame data, bits [BITS_N-1:0] are sent first
//   busy      high while a frame is in flight
//   done      one-cycle pulse once the final byte has left the line
//   dropped   one-cycle pulse for a start request seen while busy
//   data_tx   byte presented to uart_tx
//   valid     byte-valid to uart_tx
//   tx_ready  uart_tx idle/ready
module uart_frame_sender #(
  parameter int                PAYLOAD_BYTES = 4,
  parameter int                BITS_N        = 8,
  parameter logic [BITS_N-1:0] SOF_BYTE      = 8'hA5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [PAYLOAD_BYTES*BITS_N-1:0] payload,
  output logic                            busy,
  output logic                            done,
  output logic                            dropped,
  output logic [BITS_N-1:0]               data_tx,
  output logic                            valid,
  input  logic                            tx_ready
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Index of the checksum byte, and of the final payload byte.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_BYTES);

  logic [1:0]                      state_reg;
  logic [IDX_W-1:0]                idx_reg;
  logic                            last_reg;
  logic [BITS_N-1:0]               checksum_reg;
  logic [PAYLOAD_BYTES*BITS_N-1:0] payload_reg;
  logic                            busy_reg;
  logic                            done_reg;
  logic                            dropped_reg;
  logic                            valid_reg;
  logic [BITS_N-1:0]               data_tx_reg;

  logic [BITS_N-1:0]               pay_bytes [PAYLOAD_BYTES];
  logic [BITS_N-1:0]               byte_next;

  generate
    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_split
      assign pay_bytes[gi] = payload_reg[gi*BITS_N +: BITS_N];
    end
  endgenerate

  // Byte selected by the current frame index. Index 0 is SOF.
  // Indices 1..PAYLOAD_BYTES are payload bytes. The final index is the
  // checksum. By the time the checksum is needed, the checksum register
  // already holds every payload byte.
  always_comb begin
    byte_next = checksum_reg;
    if (idx_reg == '0) begin
      byte_next = SOF_BYTE;
    end
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (idx_reg == IDX_W'(i + 1)) begin
        byte_next = pay_bytes[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      last_reg     <= 1'b0;
      checksum_reg <= '0;
      payload_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      dropped_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      data_tx_reg  <= '0;
    end else begin
      done_reg    <= 1'b0;
      dropped_reg <= start && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            payload_reg  <= payload;
            idx_reg      <= '0;
            last_reg     <= 1'b0;
            checksum_reg <= '0;
            busy_reg     <= 1'b1;
            valid_reg    <= 1'b1;
            data_tx_reg  <= SOF_BYTE;
            state_reg    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            valid_reg <= 1'b0;
            if ((idx_reg != '0) && (idx_reg <= PAY_LAST)) begin
              checksum_reg <= checksum_reg ^ data_tx_reg;
            end
            // When the checksum byte is accepted, the index stays where it
            // is and a flag is set instead. This keeps the counter from
            // overflowing when PAYLOAD_BYTES+2 is a power of two.
            if (idx_reg == LAST_IDX) begin
              last_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // For one cycle after acceptance, uart_tx may still show ready.
          // That stale ready must not count as a new handshake.
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_ready) begin
            if (last_reg) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              valid_reg   <= 1'b1;
              data_tx_reg <= byte_next;
              state_reg   <= ST_SEND;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign dropped = dropped_reg;
  assign valid   = valid_reg;
  assign data_tx = data_tx_reg;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Testbench for uart_frame_sender. It uses a behavioural uart_tx stand-in:
// after each accepted byte, tx_ready stays low for d_low cycles. In uart
// mode the stand-in also shifts the byte out as a serial 8N1 line, and a
// separate receiver decodes that line.
module tb_uart_frame_sender;

  localparam int CPB = 434;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] payload = '0;
  logic        busy, done, dropped, valid, tx_ready;
  logic [7:0]  data_tx;

  uart_frame_sender dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .payload  (payload),
    .busy     (busy),
    .done     (done),
    .dropped  (dropped),
    .data_tx  (data_tx),
    .valid    (valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // uart_tx stand-in and monitors
  int         cyc = 0;
  int         d_low = 0;
  bit         uart_mode = 0;
  int         busy_cnt = 0;
  logic [9:0] tx_bits = 10'h3FF;
  logic [3:0] bit_sel;
  logic       line;
  logic [7:0] acc_q[$];
  int         acc_cyc[$];
  int         done_cnt = 0, done_cyc = 0, drop_cnt = 0;
  int         hold_viol = 0, stable_viol = 0;
  bit         prev_acc = 0, prev_valid = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q[$];

  assign tx_ready = (busy_cnt == 0);
  assign bit_sel  = 4'((d_low - busy_cnt) / CPB);

  always_comb begin
    line = 1'b1;
    if (uart_mode && busy_cnt != 0) line = tx_bits[bit_sel];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      busy_cnt <= 0;
    end else if (valid && tx_ready) begin
      acc_q.push_back(data_tx);
      acc_cyc.push_back(cyc);
      busy_cnt <= d_low;
      tx_bits  <= {1'b1, data_tx, 1'b0};
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (!reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!reset && dropped) drop_cnt++;
    if (!reset) begin
      if (prev_acc && valid) hold_viol++;
      if (prev_valid && !prev_acc && (!valid || data_tx !== prev_data)) stable_viol++;
    end
    prev_acc   = !reset && valid && tx_ready;
    prev_valid = !reset && valid;
    prev_data  = data_tx;
  end

  // Serial line receiver: sample mid-bit, LSB first
  bit         rx_active = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (reset || !uart_mode) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (line == 1'b0) begin
        rx_active = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      for (int k = 1; k <= 8; k++)
        if (rx_cnt == CPB/2 + k*CPB) rx_byte = {line, rx_byte[7:1]};
      if (rx_cnt == CPB/2 + 9*CPB) begin
        rx_q.push_back(rx_byte);
        rx_active = 0;
      end
    end
  end

  // Reference frame: SOF, payload bytes LSB first, XOR of payload bytes
  function automatic void build_frame(input logic [31:0] p);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(p[8*i +: 8]);
      x = x ^ p[8*i +: 8];
    end
    exp_q.push_back(x);
  endfunction

  int start_edge = 0;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] p);
    @(negedge clk);
    acc_q.delete();
    acc_cyc.delete();
    build_frame(p);
    start = 1'b1;
    payload = p;
    @(negedge clk);
    start = 1'b0;
    start_edge = cyc - 1;
  endtask

  task automatic wait_done(input int n0, input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt <= n0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cnt > n0);
  endtask

  task automatic wait_accepts(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (acc_q.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (data_tx !== 8'h00) begin bad++; $display("FAIL reset_data_tx: got %h want 00", data_tx); end
    $display("reset: busy=%b valid=%b data_tx=%h", busy, valid, data_tx);
  endtask

  task automatic test_basic();
    bit ok;
    int d0, lat;
    uart_mode = 1;
    d_low = 10 * CPB;
    d0 = done_cnt;
    rx_q.delete();
    start_frame(32'h64636261);
    wait_done(d0, 30000, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    lat = done_cyc - start_edge;
    total++; if (acc_q.size() != 6) begin bad++; $display("FAIL basic_accepts: got %0d want 6", acc_q.size()); end
    total++; if (rx_q.size() != 6) begin bad++; $display("FAIL basic_line_bytes: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < acc_q.size()) begin
        total++;
        if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      end
      if (i < rx_q.size()) begin
        total++;
        if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_line%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
    total++; if (lat < 60*CPB || lat > 60*CPB + 40) begin bad++; $display("FAIL basic_latency: got %0d want about %0d", lat, 60*CPB); end
    repeat (20) @(negedge clk);
    total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - d0, 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    $display("basic: accepts=%0d line_bytes=%0d latency=%0d", acc_q.size(), rx_q.size(), lat);
    uart_mode = 0;
  endtask

  task automatic test_handshake();
    bit ok;
    logic [31:0] p;
    for (int it = 0; it < 3; it++) begin
      d_low = (it == 0) ? 3 : int'($urandom_range(1, 6));
      p = $urandom;
      hold_viol = 0;
      stable_viol = 0;
      start_frame(p);
      wait_done(done_cnt, 500, ok);
      total++; if (!ok) begin bad++; $display("FAIL hs_timeout: got no done want done"); end
      total++; if (acc_q.size() != 6) begin bad++; $display("FAIL hs_accepts: got %0d want 6", acc_q.size()); end
      for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
        total++;
        if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL hs_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      end
      total++; if (hold_viol != 0) begin bad++; $display("FAIL hs_hold_valid: got %0d want 0", hold_viol); end
      total++; if (stable_viol != 0) begin bad++; $display("FAIL hs_stable: got %0d want 0", stable_viol); end
      $display("handshake: d_low=%0d payload=%h checksum=%h", d_low, p, exp_q[5]);
    end
  endtask

  task automatic test_busy_drop();
    bit ok;
    int dr0;
    d_low = 3;
    dr0 = drop_cnt;
    start_frame(32'h04030201);
    wait_accepts(2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_wait: got %0d accepts want 2", acc_q.size()); end
    @(negedge clk);
    start = 1'b1;
    payload = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(done_cnt, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_timeout: got no done want done"); end
    total++; if (drop_cnt != dr0 + 1) begin bad++; $display("FAIL drop_pulses: got %0d want 1", drop_cnt - dr0); end
    total++; if (acc_q.size() != 6) begin bad++; $display("FAIL drop_accepts: got %0d want 6", acc_q.size()); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    $display("busy_drop: dropped pulses=%0d accepts=%0d", drop_cnt - dr0, acc_q.size());
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n, d_edge;
    logic [31:0] p;
    d_low = 2;
    p = $urandom;
    start_frame(p);
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", done); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_first_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    // Start in the same cycle as the done pulse
    acc_q.delete();
    acc_cyc.delete();
    build_frame(32'h00000000);
    start = 1'b1;
    payload = 32'h00000000;
    @(negedge clk);
    start = 1'b0;
    d_edge = done_cyc;
    wait_done(done_cnt, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got no done want done"); end
    total++; if (acc_q.size() != 6) begin bad++; $display("FAIL b2b_accepts: got %0d want 6", acc_q.size()); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    if (acc_cyc.size() > 0) begin
      total++;
      if (acc_cyc[0] != d_edge + 1) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", acc_cyc[0] - d_edge, 1); end
    end
    $display("back_to_back: second frame accepts=%0d", acc_q.size());
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    logic [31:0] p;
    d_low = 3;
    p = $urandom;
    start_frame(p);
    wait_accepts(2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_wait: got %0d accepts want 2", acc_q.size()); end
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt - d0); end
    p = $urandom;
    start_frame(p);
    wait_done(done_cnt, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout: got no done want done"); end
    total++; if (acc_q.size() != 6) begin bad++; $display("FAIL rmid_accepts: got %0d want 6", acc_q.size()); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    $display("reset_mid: restart payload=%h accepts=%0d", p, acc_q.size());
  endtask

  task automatic test_ideal();
    bit ok;
    logic [31:0] p;
    d_low = 0;
    p = $urandom;
    @(negedge clk);
    acc_q.delete();
    acc_cyc.delete();
    build_frame(p);
    start = 1'b1;
    payload = p;
    @(negedge clk);
    start = 1'b0;
    start_edge = cyc - 1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL ideal_valid_latency: got %b want 1", valid); end
    total++; if (data_tx !== 8'hA5) begin bad++; $display("FAIL ideal_sof: got %h want a5", data_tx); end
    wait_done(done_cnt, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL ideal_timeout: got no done want done"); end
    total++; if (acc_q.size() != 6) begin bad++; $display("FAIL ideal_accepts: got %0d want 6", acc_q.size()); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] !== exp_q[i]) begin bad++; $display("FAIL ideal_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      total++;
      if (acc_cyc[i] != start_edge + 1 + 3*i) begin
        bad++;
        $display("FAIL ideal_accept_cycle%0d: got %0d want %0d", i, acc_cyc[i] - start_edge, 1 + 3*i);
      end
    end
    $display("ideal: payload=%h accepts=%0d", p, acc_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid();
    test_ideal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
